hockey_core_p: RTL and testbench



---
 rtl/hockey_pkg.sv | 26 ++
 rtl/hockey_puck_step.sv | 38 +++
 rtl/hockey_core_p.sv | 224 ++++++++++++++++++++++
 tb/tb_hockey_core_p.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/hockey_pkg.sv
// Shared types and constants for the parametrised air-hockey controller.
package hockey_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_DISPLAY   = 4'd1,
    S_HIT_A     = 4'd2,
    S_HIT_B     = 4'd3,
    S_SEND_A    = 4'd4,
    S_SEND_B    = 4'd5,
    S_RESP_A    = 4'd6,
    S_RESP_B    = 4'd7,
    S_GOAL_A    = 4'd8,
    S_GOAL_B    = 4'd9,
    S_GAME_OVER = 4'd10
  } state_e;

  localparam logic [1:0] DIR_STRAIGHT = 2'b00;
  localparam logic [1:0] DIR_UP       = 2'b01;
  localparam logic [1:0] DIR_DOWN     = 2'b10;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_A    = 2'b01;
  localparam logic [1:0] WIN_B    = 2'b10;

endpackage

// File: rtl/hockey_puck_step.sv
// One vertical puck step with reflection at row 0 and row Y_MAX.
module hockey_puck_step
  import hockey_pkg::*;
#(
  parameter int Y_MAX = 4,
  parameter int YW    = $clog2(Y_MAX + 1)
) (
  input  logic [YW-1:0] y_i,
  input  logic [1:0]    dir_i,
  output logic [YW-1:0] y_o,
  output logic [1:0]    dir_o
);

  localparam logic [YW-1:0] YMAX_V = YW'(Y_MAX);

  always_comb begin
    y_o   = y_i;
    dir_o = dir_i;
    case (dir_i)
      DIR_UP:
        if (y_i == YMAX_V) begin
          dir_o = DIR_DOWN;
          y_o   = YMAX_V - YW'(1);
        end else begin
          y_o = y_i + YW'(1);
        end
      DIR_DOWN:
        if (y_i == '0) begin
          dir_o = DIR_UP;
          y_o   = YW'(1);
        end else begin
          y_o = y_i - YW'(1);
        end
      default: ;
    endcase
  end

endmodule

// File: rtl/hockey_core_p.sv
// Air-hockey game sequencer: serve, rally with speed-up, scoring and game over.
module hockey_core_p
  import hockey_pkg::*;
#(
  parameter int X_MAX      = 4,
  parameter int Y_MAX      = 4,
  parameter int WIN_SCORE  = 3,
  parameter int STEP_TICKS = 3,
  parameter int MIN_TICKS  = 1,
  parameter int RESP_TICKS = 3,
  parameter int OVER_TICKS = 3,
  parameter int XW         = $clog2(X_MAX + 1),
  parameter int YW         = $clog2(Y_MAX + 1),
  parameter int SW         = $clog2(WIN_SCORE + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btn_a,
  input  logic          btn_b,
  input  logic [1:0]    dir_a,
  input  logic [1:0]    dir_b,
  input  logic [YW-1:0] y_in_a,
  input  logic [YW-1:0] y_in_b,
  output logic [XW-1:0] x_coord,
  output logic [YW-1:0] y_coord,
  output logic [3:0]    state_o,
  output logic [SW-1:0] score_a,
  output logic [SW-1:0] score_b,
  output logic [1:0]    winner,
  output logic          game_over,
  output logic [7:0]    volley_cnt
);

  localparam int MAXT = (STEP_TICKS > RESP_TICKS)
                        ? ((STEP_TICKS > OVER_TICKS) ? STEP_TICKS : OVER_TICKS)
                        : ((RESP_TICKS > OVER_TICKS) ? RESP_TICKS : OVER_TICKS);
  localparam int CW = $clog2(MAXT + 1);

  localparam logic [CW-1:0] STEP_V  = CW'(STEP_TICKS);
  localparam logic [CW-1:0] MIN_V   = CW'(MIN_TICKS);
  localparam logic [CW-1:0] STEP_M1 = CW'(STEP_TICKS - 1);
  localparam logic [CW-1:0] RESP_M1 = CW'(RESP_TICKS - 1);
  localparam logic [CW-1:0] OVER_M1 = CW'(OVER_TICKS - 1);
  localparam logic [XW-1:0] XMAX_V  = XW'(X_MAX);
  localparam logic [YW-1:0] YMAX_V  = YW'(Y_MAX);
  localparam logic [SW-1:0] WIN_V   = SW'(WIN_SCORE);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cur_q, cur_d;
  logic [XW-1:0] x_q, x_d, x_inc, x_dec;
  logic [YW-1:0] y_q, y_d, snd_y, ret_y;
  logic [1:0]    dir_q, dir_d, snd_dir, ret_dir, ret_dir_in;
  logic [SW-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [1:0]    win_q, win_d;
  logic          go_q, go_d, server_q, server_d;
  logic [7:0]    volley_q, volley_d, volley_inc;
  logic [CW-1:0] cur_dec;

  // Flight steps follow the puck's own direction; a return uses the hitter's.
  hockey_puck_step #(.Y_MAX(Y_MAX), .YW(YW)) u_send_step (
    .y_i(y_q), .dir_i(dir_q), .y_o(snd_y), .dir_o(snd_dir)
  );

  hockey_puck_step #(.Y_MAX(Y_MAX), .YW(YW)) u_ret_step (
    .y_i(y_q), .dir_i(ret_dir_in), .y_o(ret_y), .dir_o(ret_dir)
  );

  assign ret_dir_in = (state_q == S_RESP_A) ? dir_a : dir_b;
  assign x_inc      = x_q + XW'(1);
  assign x_dec      = x_q - XW'(1);
  assign cur_dec    = (cur_q > MIN_V) ? (cur_q - CW'(1)) : MIN_V;
  assign volley_inc = (volley_q == 8'hFF) ? volley_q : (volley_q + 8'd1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    cur_d    = cur_q;
    x_d      = x_q;
    y_d      = y_q;
    dir_d    = dir_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    win_d    = win_q;
    go_d     = go_q;
    server_d = server_q;
    volley_d = volley_q;
    case (state_q)
      S_IDLE:
        if (btn_a || btn_b) begin
          server_d = !btn_a;
          sa_d     = '0;
          sb_d     = '0;
          win_d    = WIN_NONE;
          go_d     = 1'b0;
          volley_d = '0;
          state_d  = S_DISPLAY;
        end
      S_DISPLAY:
        if (cnt_q == STEP_M1) state_d = server_q ? S_HIT_B : S_HIT_A;
      S_HIT_A:
        if (btn_a && (y_in_a <= YMAX_V)) begin
          x_d      = '0;
          y_d      = y_in_a;
          dir_d    = dir_a;
          cur_d    = STEP_V;
          volley_d = '0;
          state_d  = S_SEND_B;
        end
      S_HIT_B:
        if (btn_b && (y_in_b <= YMAX_V)) begin
          x_d      = XMAX_V;
          y_d      = y_in_b;
          dir_d    = dir_b;
          cur_d    = STEP_V;
          volley_d = '0;
          state_d  = S_SEND_A;
        end
      S_SEND_B:
        if (cnt_q == cur_q - CW'(1)) begin
          cnt_d = '0;
          x_d   = x_inc;
          y_d   = snd_y;
          dir_d = snd_dir;
          if (x_inc == XMAX_V) state_d = S_RESP_B;
        end
      S_SEND_A:
        if (cnt_q == cur_q - CW'(1)) begin
          cnt_d = '0;
          x_d   = x_dec;
          y_d   = snd_y;
          dir_d = snd_dir;
          if (x_dec == '0) state_d = S_RESP_A;
        end
      S_RESP_B:
        if (btn_b && (y_in_b == y_q)) begin
          x_d      = XMAX_V - XW'(1);
          y_d      = ret_y;
          dir_d    = ret_dir;
          cur_d    = cur_dec;
          volley_d = volley_inc;
          state_d  = S_SEND_A;
        end else if (cnt_q == RESP_M1) begin
          if (sa_q != WIN_V) sa_d = sa_q + SW'(1);
          state_d = S_GOAL_A;
        end
      S_RESP_A:
        if (btn_a && (y_in_a == y_q)) begin
          x_d      = XW'(1);
          y_d      = ret_y;
          dir_d    = ret_dir;
          cur_d    = cur_dec;
          volley_d = volley_inc;
          state_d  = S_SEND_B;
        end else if (cnt_q == RESP_M1) begin
          if (sb_q != WIN_V) sb_d = sb_q + SW'(1);
          state_d = S_GOAL_B;
        end
      S_GOAL_A:
        if (cnt_q == STEP_M1) begin
          if (sa_q == WIN_V) begin
            win_d   = WIN_A;
            go_d    = 1'b1;
            state_d = S_GAME_OVER;
          end else begin
            state_d = S_HIT_B;
          end
        end
      S_GOAL_B:
        if (cnt_q == STEP_M1) begin
          if (sb_q == WIN_V) begin
            win_d   = WIN_B;
            go_d    = 1'b1;
            state_d = S_GAME_OVER;
          end else begin
            state_d = S_HIT_A;
          end
        end
      S_GAME_OVER:
        if (cnt_q == OVER_M1) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      cur_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      dir_q    <= DIR_STRAIGHT;
      sa_q     <= '0;
      sb_q     <= '0;
      win_q    <= WIN_NONE;
      go_q     <= 1'b0;
      server_q <= 1'b0;
      volley_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cur_q    <= cur_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dir_q    <= dir_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      win_q    <= win_d;
      go_q     <= go_d;
      server_q <= server_d;
      volley_q <= volley_d;
    end
  end

  assign x_coord    = x_q;
  assign y_coord    = y_q;
  assign state_o    = state_q;
  assign score_a    = sa_q;
  assign score_b    = sb_q;
  assign winner     = win_q;
  assign game_over  = go_q;
  assign volley_cnt = volley_q;

endmodule

// File: tb/tb_hockey_core_p.sv
// Directed bench for hockey_core_p with default parameters (5x5 field, win at 3).
module tb_hockey_core_p;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_a = 1'b0, btn_b = 1'b0;
  logic [1:0] dir_a = 2'b00, dir_b = 2'b00;
  logic [2:0] y_in_a = '0, y_in_b = '0;
  logic [2:0] x_coord, y_coord;
  logic [3:0] state_o;
  logic [1:0] score_a, score_b, winner;
  logic       game_over;
  logic [7:0] volley_cnt;

  int checks = 0;
  int failures = 0;

  hockey_core_p dut (
    .clk(clk), .rst(rst), .btn_a(btn_a), .btn_b(btn_b),
    .dir_a(dir_a), .dir_b(dir_b), .y_in_a(y_in_a), .y_in_b(y_in_b),
    .x_coord(x_coord), .y_coord(y_coord), .state_o(state_o),
    .score_a(score_a), .score_b(score_b), .winner(winner),
    .game_over(game_over), .volley_cnt(volley_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    tick(2);
    rst = 1'b0;
    chk("rst_state", state_o, 0);
    chk("rst_x", x_coord, 0);
    chk("rst_y", y_coord, 0);
    chk("rst_sa", score_a, 0);
    chk("rst_go", game_over, 0);
    chk("rst_win", winner, 0);

    // both pressed: A serves
    btn_a = 1; btn_b = 1;
    tick(1);
    btn_a = 0; btn_b = 0;
    chk("display", state_o, 1);
    tick(2);
    chk("display_dwell", state_o, 1);
    tick(1);
    chk("hit_a", state_o, 2);

    // out-of-range paddle row is ignored
    btn_a = 1; y_in_a = 3'd6;
    tick(1);
    chk("hit_a_invalid_st", state_o, 2);
    chk("hit_a_invalid_y", y_coord, 0);

    y_in_a = 3'd2; dir_a = 2'b00;
    tick(1);
    btn_a = 0;
    chk("serve_a_st", state_o, 5);
    chk("serve_a_x", x_coord, 0);
    chk("serve_a_y", y_coord, 2);
    tick(11);
    chk("send_b_x3", x_coord, 3);
    chk("send_b_st", state_o, 5);
    tick(1);
    chk("resp_b_x", x_coord, 4);
    chk("resp_b_st", state_o, 7);

    // B misses
    tick(3);
    chk("goal_a_st", state_o, 8);
    chk("goal_a_sa1", score_a, 1);
    tick(3);
    chk("hit_b_st", state_o, 3);

    // B serves from row 0 heading down: reflects up
    btn_b = 1; y_in_b = 3'd0; dir_b = 2'b10;
    tick(1);
    btn_b = 0;
    chk("serve_b_st", state_o, 4);
    tick(3);
    chk("refl0_x", x_coord, 3);
    chk("refl0_y", y_coord, 1);
    tick(3);
    chk("refl0_y2", y_coord, 2);
    tick(6);
    chk("resp_a_st", state_o, 6);
    chk("resp_a_y", y_coord, 4);

    // A returns on the last window cycle, going up at Y_MAX reflects down
    tick(2);
    chk("window_open", state_o, 6);
    btn_a = 1; y_in_a = 3'd4; dir_a = 2'b01;
    tick(1);
    btn_a = 0;
    chk("ret1_st", state_o, 5);
    chk("ret1_x", x_coord, 1);
    chk("ret1_y", y_coord, 3);
    chk("ret1_volley", volley_cnt, 1);
    tick(1);
    chk("period2_hold", x_coord, 1);
    tick(1);
    chk("period2_step", x_coord, 2);
    tick(4);
    chk("ret1_resp_b", state_o, 7);
    chk("ret1_y_end", y_coord, 0);

    // B returns at once from row 0 going down: reflects up
    btn_b = 1; y_in_b = 3'd0; dir_b = 2'b10;
    tick(1);
    btn_b = 0;
    chk("ret2_x", x_coord, 3);
    chk("ret2_y", y_coord, 1);
    chk("ret2_volley", volley_cnt, 2);
    tick(1);
    chk("period1_step", x_coord, 2);
    tick(2);
    chk("ret2_resp_a", state_o, 6);

    btn_a = 1; y_in_a = 3'd4; dir_a = 2'b00;
    tick(1);
    btn_a = 0;
    chk("ret3_volley", volley_cnt, 3);
    tick(1);
    chk("period_floor", x_coord, 2);
    tick(2);
    chk("ret3_resp_b", state_o, 7);
    tick(3);
    chk("goal_a_sa2", score_a, 2);
    tick(3);
    chk("hit_b2", state_o, 3);

    // B serve, A returns, B misses: A reaches WIN_SCORE
    btn_b = 1; y_in_b = 3'd1; dir_b = 2'b00;
    tick(1);
    btn_b = 0;
    tick(12);
    chk("resp_a3", state_o, 6);
    btn_a = 1; y_in_a = 3'd1; dir_a = 2'b00;
    tick(1);
    btn_a = 0;
    tick(6);
    chk("resp_b3", state_o, 7);
    tick(3);
    chk("sa3", score_a, 3);
    tick(3);
    chk("over_st", state_o, 10);
    chk("over_win", winner, 1);
    chk("over_go", game_over, 1);
    tick(2);
    chk("over_dwell", state_o, 10);
    tick(1);
    chk("idle_after", state_o, 0);
    chk("idle_sa_held", score_a, 3);
    chk("idle_win_held", winner, 1);
    chk("idle_go_held", game_over, 1);

    // new game clears, B serves
    btn_b = 1;
    tick(1);
    btn_b = 0;
    chk("new_sa", score_a, 0);
    chk("new_win", winner, 0);
    chk("new_go", game_over, 0);
    tick(3);
    chk("new_hit_b", state_o, 3);

    // A misses: B scores
    btn_b = 1; y_in_b = 3'd2; dir_b = 2'b00;
    tick(1);
    btn_b = 0;
    tick(12);
    chk("resp_a4", state_o, 6);
    tick(3);
    chk("goal_b_st", state_o, 9);
    chk("goal_b_sb", score_b, 1);
    tick(3);
    chk("hit_a_after_b", state_o, 2);

    // reset mid-SEND_B
    btn_a = 1; y_in_a = 3'd1;
    tick(1);
    btn_a = 0;
    chk("send_b_again", state_o, 5);
    tick(4);
    rst = 1;
    #2;
    chk("async_rst", state_o, 0);
    tick(1);
    chk("mid_rst_x", x_coord, 0);
    chk("mid_rst_y", y_coord, 0);
    chk("mid_rst_sb", score_b, 0);
    chk("mid_rst_go", game_over, 0);
    rst = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
